// File: rtl/demux_1to4_reg_if.sv
// demux_1to4_reg_if: producer-side word/select handshake plus four consumer channels of the demux.
interface demux_1to4_reg_if #(parameter int size = 32);
  logic [size-1:0] data_i;
  logic [1:0] select_i;
  logic valid_i;
  logic ready_o;
  logic [size-1:0] data0_o, data1_o, data2_o, data3_o;
  logic valid0_o, valid1_o, valid2_o, valid3_o;
  logic ready0_i, ready1_i, ready2_i, ready3_i;
  logic [7:0] cnt0_o, cnt1_o, cnt2_o, cnt3_o;
  modport slave (
    input data_i, select_i, valid_i, ready0_i, ready1_i, ready2_i, ready3_i,
    output ready_o, data0_o, data1_o, data2_o, data3_o,
    output valid0_o, valid1_o, valid2_o, valid3_o, cnt0_o, cnt1_o, cnt2_o, cnt3_o
  );
  modport master (
    output data_i, select_i, valid_i, ready0_i, ready1_i, ready2_i, ready3_i,
    input ready_o, data0_o, data1_o, data2_o, data3_o,
    input valid0_o, valid1_o, valid2_o, valid3_o, cnt0_o, cnt1_o, cnt2_o, cnt3_o
  );
endinterface

// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: registered 1-to-4 demux, one-entry holding register and delivery counter per channel.
module demux_1to4_reg #(parameter int size = 32) (
  input logic clk_i,
  input logic rst_i,
  demux_1to4_reg_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [3:0] rdy, vld, acc;
  logic [3:0][size-1:0] dout;
  logic [3:0][7:0] cnt;
  logic acc_any;
  assign rdy = {bus.ready3_i, bus.ready2_i, bus.ready1_i, bus.ready0_i};
  // A full channel whose consumer drains this cycle can take a new word in the same edge.
  assign bus.ready_o = ~vld[bus.select_i] | rdy[bus.select_i];
  assign acc_any = bus.valid_i & bus.ready_o;
  assign acc = acc_any ? 4'b0001 << bus.select_i : 4'b0000;
  for (genvar c = 0; c < 4; c++) begin : g_ch
    logic [0:0] st_q, st_d;
    logic [size-1:0] data_q, data_d;
    logic [7:0] cnt_q, cnt_d;
    logic dlv;
    always_comb begin
      dlv = (st_q == FULL) & rdy[c];
      st_d = acc[c] ? FULL : dlv ? EMPTY : st_q;
      data_d = acc[c] ? bus.data_i : data_q;
      cnt_d = dlv ? cnt_q + 8'd1 : cnt_q;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        st_q <= EMPTY;
        data_q <= '0;
        cnt_q <= '0;
      end else begin
        st_q <= st_d;
        data_q <= data_d;
        cnt_q <= cnt_d;
      end
    end
    assign vld[c] = st_q == FULL;
    assign dout[c] = data_q;
    assign cnt[c] = cnt_q;
  end
  assign {bus.valid3_o, bus.valid2_o, bus.valid1_o, bus.valid0_o} = vld;
  assign bus.data0_o = dout[0];
  assign bus.data1_o = dout[1];
  assign bus.data2_o = dout[2];
  assign bus.data3_o = dout[3];
  assign bus.cnt0_o = cnt[0];
  assign bus.cnt1_o = cnt[1];
  assign bus.cnt2_o = cnt[2];
  assign bus.cnt3_o = cnt[3];
endmodule

// File: tb/tb_demux_1to4_reg.sv
// tb_demux_1to4_reg: directed vector table plus wrap and async-reset sequences for demux_1to4_reg.
module tb_demux_1to4_reg;
  typedef struct {
    logic valid;
    logic [1:0] sel;
    logic [31:0] data;
    logic [3:0] rdy;
    logic exp_rdy;
    logic [3:0] exp_vld;
    logic [31:0] exp_d;
    logic [31:0] exp_cnts;
  } vec_t;
  logic clk_i = 1'b0;
  logic rst_i;
  int total = 0;
  int bad = 0;
  demux_1to4_reg_if #(.size(32)) ifc ();
  demux_1to4_reg #(.size(32)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(ifc));
  always #5 clk_i = ~clk_i;
  logic [3:0] vld;
  logic [31:0] cnts;
  logic [31:0] dq [4];
  assign vld = {ifc.valid3_o, ifc.valid2_o, ifc.valid1_o, ifc.valid0_o};
  assign cnts = {ifc.cnt3_o, ifc.cnt2_o, ifc.cnt1_o, ifc.cnt0_o};
  assign dq[0] = ifc.data0_o;
  assign dq[1] = ifc.data1_o;
  assign dq[2] = ifc.data2_o;
  assign dq[3] = ifc.data3_o;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
    ifc.valid_i = v;
    ifc.select_i = s;
    ifc.data_i = d;
    {ifc.ready3_i, ifc.ready2_i, ifc.ready1_i, ifc.ready0_i} = r;
  endtask
  vec_t tv [10];
  initial begin
    tv[0] = '{1'b1, 2'd2, 32'hA5A5_0001, 4'b0000, 1'b1, 4'b0100, 32'hA5A5_0001, 32'h0000_0000};
    tv[1] = '{1'b1, 2'd2, 32'h1111_1111, 4'b0000, 1'b0, 4'b0100, 32'hA5A5_0001, 32'h0000_0000};
    tv[2] = '{1'b1, 2'd1, 32'h2222_2222, 4'b0000, 1'b1, 4'b0110, 32'h2222_2222, 32'h0000_0000};
    tv[3] = '{1'b1, 2'd3, 32'h3333_3333, 4'b0000, 1'b1, 4'b1110, 32'h3333_3333, 32'h0000_0000};
    tv[4] = '{1'b1, 2'd3, 32'h0000_00FF, 4'b1000, 1'b1, 4'b1110, 32'h0000_00FF, 32'h0100_0000};
    tv[5] = '{1'b0, 2'd0, 32'hDEAD_BEEF, 4'b0000, 1'b1, 4'b1110, 32'h0000_0000, 32'h0100_0000};
    tv[6] = '{1'b0, 2'd0, 32'hDEAD_BEEF, 4'b0001, 1'b1, 4'b1110, 32'h0000_0000, 32'h0100_0000};
    tv[7] = '{1'b0, 2'd1, 32'hDEAD_BEEF, 4'b1111, 1'b1, 4'b0000, 32'h2222_2222, 32'h0201_0100};
    tv[8] = '{1'b1, 2'd0, 32'h0000_0001, 4'b0000, 1'b1, 4'b0001, 32'h0000_0001, 32'h0201_0100};
    tv[9] = '{1'b1, 2'd0, 32'h0000_0005, 4'b0001, 1'b1, 4'b0001, 32'h0000_0005, 32'h0201_0101};
    rst_i = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    #12;
    chk("reset_vld", {28'h0, vld}, 32'h0);
    chk("reset_cnts", cnts, 32'h0);
    chk("reset_data", dq[0] | dq[1] | dq[2] | dq[3], 32'h0);
    chk("reset_ready", {31'h0, ifc.ready_o}, 32'h1);
    rst_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].valid, tv[i].sel, tv[i].data, tv[i].rdy);
      #1;
      chk($sformatf("v%0d_ready", i), {31'h0, ifc.ready_o}, {31'h0, tv[i].exp_rdy});
      step();
      chk($sformatf("v%0d_vld", i), {28'h0, vld}, {28'h0, tv[i].exp_vld});
      chk($sformatf("v%0d_data", i), dq[tv[i].sel], tv[i].exp_d);
      chk($sformatf("v%0d_cnts", i), cnts, tv[i].exp_cnts);
    end
    for (int i = 0; i < 254; i++) begin
      drive(1'b1, 2'd0, i, 4'b0001);
      step();
    end
    chk("wrap_255", {24'h0, ifc.cnt0_o}, 32'd255);
    step();
    chk("wrap_0", {24'h0, ifc.cnt0_o}, 32'd0);
    chk("wrap_vld0", {31'h0, ifc.valid0_o}, 32'h1);
    for (int c = 1; c < 4; c++) begin
      drive(1'b1, 2'(c), 32'h4000_0000 + c, 4'b0000);
      step();
    end
    chk("fill_vld", {28'h0, vld}, 32'hF);
    chk("fill_d2", ifc.data2_o, 32'h4000_0002);
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_vld", {28'h0, vld}, 32'h0);
    chk("arst_cnts", cnts, 32'h0);
    chk("arst_data", dq[0] | dq[1] | dq[2] | dq[3], 32'h0);
    chk("arst_ready", {31'h0, ifc.ready_o}, 32'h1);
    #1;
    rst_i = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 4'b1111);
    step();
    chk("post_rst_vld", {28'h0, vld}, 32'h0);
    chk("post_rst_cnts", cnts, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
